// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data-memory controller.
//   MEM_*            RV32 load/store funct3 encodings.
//   mem_ctrl_state_t controller FSM state.
//   mem_funct3_legal true when funct3 names a legal access for the given direction.
package rv32_mem_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [3:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StRdLast,
    StWrLo,
    StWrHi,
    StRmwRd,
    StRmwWr,
    StResp
  } mem_ctrl_state_t;

  function automatic logic mem_funct3_legal(input logic we, input logic [2:0] funct3);
    logic legal;
    if (we) begin
      legal = (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W);
    end else begin
      legal = (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W) ||
              (funct3 == MEM_BU) || (funct3 == MEM_HU);
    end
    return legal;
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load result formatter (combinational).
//   funct3  in  3   load type
//   lane    in  1   byte lane within the low halfword (byte address bit 0)
//   lo      in  16  halfword at h
//   hi      in  16  halfword at h+1 (used by LW only)
//   result  out 32  aligned, sign/zero-extended load value
module rv32_load_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        lane,
  input  logic [15:0] lo,
  input  logic [15:0] hi,
  output logic [31:0] result
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = lane ? lo[15:8] : lo[7:0];
    result   = '0;
    case (funct3)
      MEM_B:   result = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  result = {24'h0, byte_sel};
      MEM_H:   result = {{16{lo[15]}}, lo};
      MEM_HU:  result = {16'h0, lo};
      MEM_W:   result = {hi, lo};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_bram_mem_ctrl.sv
// Data-memory controller between the core load/store FSM and a 16-bit BRAM.
// Splits each RV32 load/store into halfword BRAM accesses: words take two halfwords,
// byte stores do a read-modify-write, loads are aligned and extended.
//   clk, reset                      single clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (ready only when idle)
//   req_we/req_funct3/req_addr/req_wdata  request fields, registered at accept
//   resp_valid/resp_ready           response handshake, response held until accepted
//   resp_rdata/resp_err             load result (0 for stores/errors), error flag
//   bram_wen/bram_waddr/bram_wdata  BRAM write port
//   bram_ren/bram_raddr/bram_rdata  BRAM read port, rdata valid the cycle after ren
module rv32_bram_mem_ctrl #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic                 bram_wen,
  output logic [ADDR_SIZE-1:0] bram_waddr,
  output logic [15:0]          bram_wdata,
  output logic                 bram_ren,
  output logic [ADDR_SIZE-1:0] bram_raddr,
  input  logic [15:0]          bram_rdata
);

  import rv32_mem_pkg::*;

  if (WORD_SIZE != 16) begin : g_word_size_check
    $error("rv32_bram_mem_ctrl: WORD_SIZE must be 16");
  end

  mem_ctrl_state_t      state_q, state_d;
  logic [ADDR_SIZE-1:0] h_q, h_d, h_next;
  logic                 lane_q, lane_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [15:0]          lo_q, lo_d, hi_q, hi_d;
  logic                 err_q, err_d;

  logic                 misalign;
  logic                 req_err;
  logic [31:0]          load_result;

  // Word accesses are aligned, so h+1 never wraps for a legal request.
  assign h_next = h_q + {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      default: misalign = 1'b0;
    endcase
    req_err = !mem_funct3_legal(req_we, req_funct3) || misalign ||
              (req_addr[31:ADDR_SIZE+1] != '0);
  end

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    lane_d   = lane_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          h_d      = req_addr[ADDR_SIZE:1];
          lane_d   = req_addr[0];
          funct3_d = req_funct3;
          we_d     = req_we;
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err) begin
            state_d = StResp;
          end else if (!req_we) begin
            state_d = StRdLo;
          end else if (req_funct3 == MEM_B) begin
            state_d = StRmwRd;
          end else begin
            state_d = StWrLo;
          end
        end
      end
      StRdLo:   state_d = (funct3_q == MEM_W) ? StRdHi : StRdLast;
      StRdHi: begin
        lo_d    = bram_rdata;
        state_d = StRdLast;
      end
      StRdLast: begin
        if (funct3_q == MEM_W) begin
          hi_d = bram_rdata;
        end else begin
          lo_d = bram_rdata;
        end
        state_d = StResp;
      end
      StWrLo:   state_d = (funct3_q == MEM_W) ? StWrHi : StResp;
      StWrHi:   state_d = StResp;
      StRmwRd:  state_d = StRmwWr;
      StRmwWr:  state_d = StResp;
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // BRAM port decode from registered state. Reset blocks the access of the current cycle so
  // an interrupted split store leaves the second halfword untouched.
  always_comb begin
    bram_wen   = 1'b0;
    bram_waddr = '0;
    bram_wdata = '0;
    bram_ren   = 1'b0;
    bram_raddr = '0;
    if (!reset) begin
      case (state_q)
        StRdLo, StRmwRd: begin
          bram_ren   = 1'b1;
          bram_raddr = h_q;
        end
        StRdHi: begin
          bram_ren   = 1'b1;
          bram_raddr = h_next;
        end
        StWrLo: begin
          bram_wen   = 1'b1;
          bram_waddr = h_q;
          bram_wdata = wdata_q[15:0];
        end
        StWrHi: begin
          bram_wen   = 1'b1;
          bram_waddr = h_next;
          bram_wdata = wdata_q[31:16];
        end
        StRmwWr: begin
          bram_wen   = 1'b1;
          bram_waddr = h_q;
          bram_wdata = lane_q ? {wdata_q[7:0], bram_rdata[7:0]}
                              : {bram_rdata[15:8], wdata_q[7:0]};
        end
        default: ;
      endcase
    end
  end

  rv32_load_align u_load_align (
    .funct3 (funct3_q),
    .lane   (lane_q),
    .lo     (lo_q),
    .hi     (hi_q),
    .result (load_result)
  );

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !err_q && !we_q) ? load_result : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      h_q      <= '0;
      lane_q   <= 1'b0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      lane_q   <= lane_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_rv32_bram_mem_ctrl.sv
// Bench for rv32_bram_mem_ctrl: DUT on a behavioural 16-bit BRAM, checked against a
// byte-array memory model.
module tb_rv32_bram_mem_ctrl;

  localparam int unsigned ADDR_SIZE = 8;
  localparam int          NBYTES    = 512;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bram_wen;
  logic [7:0]  bram_waddr;
  logic [15:0] bram_wdata;
  logic        bram_ren;
  logic [7:0]  bram_raddr;
  logic [15:0] bram_rdata;

  logic        init_we;
  logic [7:0]  init_addr;
  logic [15:0] init_data;

  logic [15:0] bram [256];
  logic [7:0]  ref_mem [NBYTES];

  int checks;
  int errors;

  rv32_bram_mem_ctrl #(
    .WORD_SIZE (16),
    .ADDR_SIZE (ADDR_SIZE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bram_wen   (bram_wen),
    .bram_waddr (bram_waddr),
    .bram_wdata (bram_wdata),
    .bram_ren   (bram_ren),
    .bram_raddr (bram_raddr),
    .bram_rdata (bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (bram_wen) bram[bram_waddr] <= bram_wdata;
    else if (init_we) bram[init_addr] <= init_data;
    if (bram_ren) bram_rdata <= bram[bram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (we) begin
      if (f3 > 3'd2) return 1'b1;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b1;
    end
    sz = 1 << f3[1:0];
    if ((a % sz) != 0) return 1'b1;
    if (a >= NBYTES) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    int i;
    logic [15:0] half;
    i = int'(a);
    half = {ref_mem[(i + 1) % NBYTES], ref_mem[i]};
    case (f3)
      3'd0:    return {{24{ref_mem[i][7]}}, ref_mem[i]};
      3'd4:    return {24'h0, ref_mem[i]};
      3'd1:    return {{16{half[15]}}, half};
      3'd5:    return {16'h0, half};
      3'd2:    return {ref_mem[i + 3], ref_mem[i + 2], half};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_latency(input bit we, input logic [2:0] f3, input bit e);
    if (e) return 1;
    if (!we) return (f3 == 3'd2) ? 4 : 3;
    return (f3 == 3'd1) ? 2 : 3;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
    int n;
    n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
  endtask

  // One request/response transaction with timing, access-count and data checks.
  // hold > 0 keeps resp_ready low that many extra cycles while pulsing stray requests.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input string tag,
                        output logic [31:0] rd);
    bit          e;
    int          cyc;
    int          nren;
    int          nwen;
    int          exp_ren;
    int          exp_wen;
    logic [31:0] er;
    e  = exp_err(we, f3, a);
    er = (e || we) ? 32'h0 : exp_load(f3, a);
    exp_ren = 0;
    exp_wen = 0;
    if (!e) begin
      if (!we) exp_ren = (f3 == 3'd2) ? 2 : 1;
      else if (f3 == 3'd0) begin exp_ren = 1; exp_wen = 1; end
      else exp_wen = (f3 == 3'd2) ? 2 : 1;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    cyc  = 1;
    nren = 0;
    nwen = 0;
    while (resp_valid !== 1'b1 && cyc < 12) begin
      nren += int'(bram_ren);
      nwen += int'(bram_wen);
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_latency"}, cyc, exp_latency(we, f3, e));
    check({tag, "_rdata"}, resp_rdata, er);
    check({tag, "_err"}, resp_err, e);
    check({tag, "_ren_count"}, nren, exp_ren);
    check({tag, "_wen_count"}, nwen, exp_wen);
    check({tag, "_idle_bram"}, {bram_ren, bram_wen}, 2'b00);
    if (!e && we) model_store(f3, a, wd);
    for (int i = 0; i < hold; i++) begin
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h30;
      req_wdata  = $urandom;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check({tag, "_hold_valid"}, resp_valid, 1'b1);
      check({tag, "_hold_rdata"}, resp_rdata, er);
      check({tag, "_hold_err"}, resp_err, e);
      check({tag, "_hold_ready"}, req_ready, 1'b0);
      check({tag, "_hold_bram"}, {bram_ren, bram_wen}, 2'b00);
    end
    rd = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_done_valid"}, resp_valid, 1'b0);
    check({tag, "_done_ready"}, req_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_resp_err"}, resp_err, 1'b0);
    check({tag, "_bram_en"}, {bram_ren, bram_wen}, 2'b00);
    check({tag, "_bram_addr"}, {bram_raddr, bram_waddr}, 16'h0);
    check({tag, "_bram_wdata"}, bram_wdata, 16'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [2:0]  f3;
    bit          we;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    init_we    = 1'b0;
    init_addr  = 8'h0;
    init_data  = 16'h0;

    // Fill BRAM with random contents while reset holds the DUT idle.
    for (int i = 0; i < 256; i++) begin
      init_we   = 1'b1;
      init_addr = 8'(i);
      init_data = 16'($urandom);
      ref_mem[2*i]     = init_data[7:0];
      ref_mem[2*i + 1] = init_data[15:8];
      @(posedge clk);
      #1;
    end
    init_we = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: split word store and load.
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "t1_sw", rd);
    check("t1_bram_h8", {16'h0, bram[8]}, 32'h0000BEEF);
    check("t1_bram_h9", {16'h0, bram[9]}, 32'h0000DEAD);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, "t1_lw", rd);
    check("t1_lw_const", rd, 32'hDEADBEEF);

    // 2: byte store via read-modify-write, then extended loads.
    do_req(1'b1, 3'd0, 32'h11, 32'h000000AA, 0, "t2_sb", rd);
    check("t2_bram_h8", {16'h0, bram[8]}, 32'h0000AAEF);
    do_req(1'b0, 3'd4, 32'h11, 32'h0, 0, "t2_lbu", rd);
    check("t2_lbu_const", rd, 32'h000000AA);
    do_req(1'b0, 3'd0, 32'h11, 32'h0, 0, "t2_lb", rd);
    check("t2_lb_const", rd, 32'hFFFFFFAA);
    do_req(1'b0, 3'd1, 32'h10, 32'h0, 0, "t2_lh", rd);
    check("t2_lh_const", rd, 32'hFFFFAAEF);
    do_req(1'b0, 3'd5, 32'h10, 32'h0, 0, "t2_lhu", rd);
    check("t2_lhu_const", rd, 32'h0000AAEF);

    // 3: misaligned and illegal funct3.
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 0, "t3_lw_mis", rd);
    do_req(1'b1, 3'd1, 32'h11, 32'h5555, 0, "t3_sh_mis", rd);
    do_req(1'b0, 3'd3, 32'h10, 32'h0, 0, "t3_f3_bad", rd);

    // 4: range boundary.
    do_req(1'b0, 3'd2, 32'h1FC, 32'h0, 0, "t4_lw_top", rd);
    do_req(1'b0, 3'd2, 32'h200, 32'h0, 0, "t4_lw_oor", rd);

    // 5: response held with resp_ready low; stray requests ignored.
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, "t5_lw_hold", rd);
    check("t5_lw_const", rd, 32'hDEADAAEF);
    do_req(1'b0, 3'd2, 32'h30, 32'h0, 0, "t5_lw_30", rd);

    // 6: reset during the high half of a split store.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("t6_wr_lo", {bram_wen, 7'h0, bram_waddr, bram_wdata}, {1'b1, 7'h0, 8'h10, 16'h5678});
    @(posedge clk);
    #1;
    check("t6_wr_hi", {bram_wen, 7'h0, bram_waddr, bram_wdata}, {1'b1, 7'h0, 8'h11, 16'h1234});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("t6_after_reset");
    ref_mem[32'h20] = 8'h78;
    ref_mem[32'h21] = 8'h56;
    do_req(1'b0, 3'd5, 32'h20, 32'h0, 0, "t6_lhu_lo", rd);
    check("t6_lhu_const", rd, 32'h00005678);
    do_req(1'b0, 3'd5, 32'h22, 32'h0, 0, "t6_lhu_hi", rd);

    // Randomized traffic against the byte model.
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(9, 31));
      do_req(we, f3, a, $urandom, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
